// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, stall replay, redirect with one bubble.
// Optional FETCH_BOUND_CHECK_EN halts fetch beyond MEM_LAST_ADDR.
module fetch_unit #(
    parameter logic [6:0] RESET_PC      = 7'd0,
    parameter logic [6:0] MEM_LAST_ADDR = 7'd72
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [6:0]  redirect_target,
    output logic [6:0]  read_address,
    input  logic [31:0] inst_in,
    output logic        if_valid,
    output logic [6:0]  if_pc,
    output logic [31:0] if_inst,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    localparam logic [6:0] BOOT_PC = {RESET_PC[6:2], 2'b00};

`ifdef FETCH_BOUND_CHECK_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    state_t     state, next_state;
    logic [6:0] pc, next_pc;
    logic [6:0] next_if_pc;
    logic       next_if_valid;
    logic [6:0] target_aligned;

    assign target_aligned = {redirect_target[6:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= BOOT_PC;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            state    <= next_state;
            pc       <= next_pc;
            if_pc    <= next_if_pc;
            if_valid <= next_if_valid;
        end
    end

    always_comb begin
        next_state    = state;
        next_pc       = pc;
        next_if_pc    = if_pc;
        next_if_valid = if_valid;
        read_address  = pc;

        case (state)
            BOOT: begin
                // Nothing is held yet in BOOT, so a stall keeps presenting pc.
                if (redirect_valid) begin
                    next_pc       = target_aligned;
                    next_if_valid = 1'b0;
                end else if (stall) begin
                    next_if_valid = 1'b0;
                end else begin
                    next_state    = RUN;
                    next_if_pc    = pc;
                    next_pc       = pc + 7'd4;
                    next_if_valid = 1'b1;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    next_pc       = target_aligned;
                    next_if_valid = 1'b0;
                end else if (stall) begin
                    // Re-read the held address so the word reappears next cycle.
                    read_address = if_pc;
                end else if (BOUND_EN && (pc > MEM_LAST_ADDR)) begin
                    next_state    = HALT;
                    next_if_valid = 1'b0;
                end else begin
                    next_if_pc    = pc;
                    next_pc       = pc + 7'd4;
                    next_if_valid = 1'b1;
                end
            end
            HALT: begin
                next_if_valid = 1'b0;
                if (redirect_valid) begin
                    next_pc    = target_aligned;
                    next_state = BOOT;
                end
            end
            default: begin
                next_state    = BOOT;
                next_pc       = BOOT_PC;
                next_if_valid = 1'b0;
            end
        endcase
    end

    assign if_inst = if_valid ? inst_in : '0;

`ifdef FETCH_BOUND_CHECK_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit with a one-cycle-latency instruction memory
// model and a scoreboard queue of expected post-edge outputs.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [6:0]  redirect_target;
    logic [6:0]  read_address;
    logic [31:0] inst_in;
    logic        if_valid;
    logic [6:0]  if_pc;
    logic [31:0] if_inst;
    logic        halted;

    int checks;
    int errors;

    typedef struct {
        logic       stall;
        logic       redir;
        logic [6:0] tgt;
        logic [6:0] ra;
        logic       v;
        logic [6:0] pc;
        logic       h;
    } vec_t;

    typedef struct {
        logic       v;
        logic [6:0] pc;
        logic       h;
    } exp_t;

    vec_t tbl1[$];
    vec_t tbl2[$];
    exp_t sb[$];

    fetch_unit #(
        .RESET_PC      (7'd0),
        .MEM_LAST_ADDR (7'd72)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .read_address    (read_address),
        .inst_in         (inst_in),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [6:0] a);
        return {8'h5A, 1'b0, a, 9'h0A5, a};
    endfunction

    always @(posedge clk) inst_in <= memf(read_address);

    function automatic vec_t mk(input logic s, input logic r, input logic [6:0] t,
                                input logic [6:0] ra, input logic v,
                                input logic [6:0] pc, input logic h);
        vec_t x;
        x.stall = s; x.redir = r; x.tgt = t; x.ra = ra; x.v = v; x.pc = pc; x.h = h;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("if_valid", {31'd0, if_valid}, {31'd0, e.v});
            check("halted", {31'd0, halted}, {31'd0, e.h});
            check("if_inst", if_inst, e.v ? memf(e.pc) : 32'h0);
            if (e.v) check("if_pc", {25'd0, if_pc}, {25'd0, e.pc});
        end
    end

    task automatic run_vec(input vec_t x);
        exp_t e;
        stall           = x.stall;
        redirect_valid  = x.redir;
        redirect_target = x.tgt;
        #1;
        check("read_address", {25'd0, read_address}, {25'd0, x.ra});
        e.v = x.v; e.pc = x.pc; e.h = x.h;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_if_pc"}, {25'd0, if_pc}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_read_address"}, {25'd0, read_address}, 32'd0);
        check({tag, "_if_inst"}, if_inst, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;

        //             stall redir tgt     ra      v     pc     h
        tbl1.push_back(mk(0, 0, 7'd0,  7'd0,  1, 7'd0,  0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd4,  1, 7'd4,  0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd8,  1, 7'd8,  0));
        tbl1.push_back(mk(1, 0, 7'd0,  7'd8,  1, 7'd8,  0));
        tbl1.push_back(mk(1, 0, 7'd0,  7'd8,  1, 7'd8,  0));
        tbl1.push_back(mk(1, 0, 7'd0,  7'd8,  1, 7'd8,  0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd12, 1, 7'd12, 0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd16, 1, 7'd16, 0));
        tbl1.push_back(mk(0, 1, 7'd41, 7'd20, 0, 7'd0,  0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd40, 1, 7'd40, 0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd44, 1, 7'd44, 0));
        tbl1.push_back(mk(1, 1, 7'd20, 7'd48, 0, 7'd0,  0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd20, 1, 7'd20, 0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd24, 1, 7'd24, 0));
        tbl1.push_back(mk(0, 0, 7'd0,  7'd28, 1, 7'd28, 0));

        tbl2.push_back(mk(1, 0, 7'd0,  7'd0,  0, 7'd0,  0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd0,  1, 7'd0,  0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd4,  1, 7'd4,  0));
`ifdef FETCH_BOUND_CHECK_EN
        tbl2.push_back(mk(0, 1, 7'd64, 7'd8,  0, 7'd0,  0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd64, 1, 7'd64, 0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd68, 1, 7'd68, 0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd72, 1, 7'd72, 0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd76, 0, 7'd0,  1));
        tbl2.push_back(mk(1, 0, 7'd0,  7'd76, 0, 7'd0,  1));
        tbl2.push_back(mk(0, 1, 7'd0,  7'd76, 0, 7'd0,  0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd0,  1, 7'd0,  0));
        tbl2.push_back(mk(0, 0, 7'd0,  7'd4,  1, 7'd4,  0));
`else
        tbl2.push_back(mk(0, 1, 7'd116, 7'd8,   0, 7'd0,   0));
        tbl2.push_back(mk(0, 0, 7'd0,   7'd116, 1, 7'd116, 0));
        tbl2.push_back(mk(0, 0, 7'd0,   7'd120, 1, 7'd120, 0));
        tbl2.push_back(mk(0, 0, 7'd0,   7'd124, 1, 7'd124, 0));
        tbl2.push_back(mk(0, 0, 7'd0,   7'd0,   1, 7'd0,   0));
        tbl2.push_back(mk(0, 0, 7'd0,   7'd4,   1, 7'd4,   0));
`endif

        #2;
        check_reset_state("reset");
        @(negedge clk);
        check("reset_hold_if_valid", {31'd0, if_valid}, 32'd0);

        rst_n = 1'b1;
        foreach (tbl1[i]) run_vec(tbl1[i]);

        // Asynchronous reset pulse mid-run, between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midrun_reset");
        @(negedge clk);
        check("midrun_reset_hold_if_valid", {31'd0, if_valid}, 32'd0);
        rst_n = 1'b1;
        foreach (tbl2[i]) run_vec(tbl2[i]);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 7'd0: first byte address fetched after reset.
REQ-002 Parameter MEM_LAST_ADDR, default 7'd72: highest legal word-aligned fetch address (76-byte instruction store).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  downstream cannot accept; hold the current fetched instruction.
REQ-006 redirect_valid  input  1  branch/jump taken this cycle.
REQ-007 redirect_target  input  7  byte address of the redirect target.
REQ-008 read_address  output  7  byte address to the instruction memory; the memory samples it on posedge clk.
REQ-009 inst_in  input  32  instruction word from the memory; valid the cycle after its address was sampled.
REQ-010 if_valid  output  1  if_inst/if_pc hold a real instruction this cycle.
REQ-011 if_pc  output  7  byte address of the instruction in if_inst.
REQ-012 if_inst  output  32  equals inst_in when if_valid=1, else 32'h0000_0000 (NOP).
REQ-013 halted  output  1  fetch stopped at the memory bound.

Function
REQ-014 Registers: pc (next address to fetch), if_pc, if_valid, and state in {BOOT, RUN, HALT}.
REQ-015 read_address = if_pc when stall=1 and redirect_valid=0, else pc; this replays the held instruction so the one-cycle memory latency never loses it.
REQ-016 RUN, no stall, no redirect: at the edge, if_pc<=pc, pc<=pc+4 (7-bit, modulo 128), if_valid<=1.
REQ-017 Stall with no redirect: pc, if_pc, and if_valid hold; if_inst shows the same word again the next cycle.
REQ-018 Redirect overrides stall: at the edge, pc<={redirect_target[6:2],2'b00}, if_valid<=0; the word fetched at that edge is discarded.
REQ-019 Redirect penalty is exactly one bubble cycle; if_valid=1 with if_pc=target two cycles after redirect_valid is sampled.
REQ-020 BOOT: the first edge after reset fetches RESET_PC; state moves to RUN, pc<=RESET_PC+4, if_pc<=RESET_PC, if_valid<=1, unless stall or redirect is active.
REQ-021 In BOOT, stall holds BOOT with if_valid=0; redirect loads pc and stays in BOOT.
REQ-022 RESET_PC low two bits are treated as 00.
REQ-023 redirect_valid and stall are sampled only at posedge; read_address is the only combinational path from inputs.

Reset
REQ-024 On rst_n=0, immediately: pc=RESET_PC, if_pc=0, if_valid=0, halted=0, state=BOOT, read_address=RESET_PC.
REQ-025 rst_n asserted mid-stall or mid-redirect discards all in-flight state; no partial update survives.
REQ-026 Release of rst_n takes effect at the first posedge with rst_n=1.

Configuration
REQ-027 Macro FETCH_BOUND_CHECK_EN: when defined, a RUN cycle with pc>MEM_LAST_ADDR (unstalled, no redirect) moves to HALT instead of fetching.
REQ-028 HALT: if_valid<=0, halted=1, pc frozen, read_address=pc; stall is ignored.
REQ-029 In HALT, only redirect_valid (returns to BOOT-like fetch of target, halted<=0) or reset exits.
REQ-030 Without FETCH_BOUND_CHECK_EN: HALT is unreachable, halted is tied to 0, and pc wraps 124->0.

Verification
REQ-031 Reset then 4 free-running cycles: read_address 0,4,8,12; if_pc 0,4,8 with if_valid=1 from cycle 2; if_valid=0 and if_inst=0 in cycle 1.
REQ-032 stall=1 for 3 cycles while if_pc=8: if_pc stays 8, read_address=8, if_inst constant; after release, if_pc=12 on the next cycle.
REQ-033 redirect_valid=1 with target=7'd41 while if_pc=16: next cycle if_valid=0, read_address=40; the following cycle if_pc=40, if_valid=1.
REQ-034 stall=1 and redirect_valid=1 together (target 20): redirect wins; if_pc=20 two cycles later.
REQ-035 With FETCH_BOUND_CHECK_EN, run from 64: if_pc 64,68,72, then halted=1, if_valid=0; redirect to 0 resumes with if_pc=0 two cycles later. Without the macro: pc reaches 124, then read_address=0.
REQ-036 rst_n pulsed low mid-run at if_pc=28: outputs immediately match REQ-024; fetch restarts at RESET_PC.
